// File: rtl/charlie_scanner_pkg.sv
// Shared types and helpers for the charlieplexed LED scanner.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package charlie_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_DRIVE = 2'd2
    } state_e;

    // Narrowest width any counter or index is allowed to collapse to.
    localparam int MIN_W = 1;

    // Bits needed to hold the values 0 .. n-1, never less than MIN_W.
    function automatic int width_of(input int n);
        return (n <= 2) ? MIN_W : $clog2(n);
    endfunction

    // Column c of row r sits on pin c, skipping over the anode pin r.
    function automatic int col_to_pin(input int row, input int col);
        return (col < row) ? col : col + 1;
    endfunction

endpackage

// File: rtl/charlie_scanner_scan_timer.sv
// Terminal-count down-counter timing the blank and dwell phases.
// Latency: load takes effect on the next edge; done is combinational from the count.
// Backpressure: none, free-running once loaded.
module scan_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic [W-1:0] count_o,
    output logic         done_o
);

    logic [W-1:0] count_q;

    // Reload on phase entry, otherwise count down and park at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (count_q != '0) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign count_o = count_q;
    assign done_o  = (count_q == '0);

endmodule

// File: rtl/charlie_scanner.sv
// Charlieplexed LED matrix scanner with blanking, frame double-buffer and PWM brightness.
// Latency: outputs registered; frame_start one cycle after en is accepted, row 0 drive after BLANK more.
// Backpressure: none; pixels/brightness are sampled only at frame boundaries.
module charlie_scanner
    import charlie_pkg::*;
#(
    parameter int PINS  = 6,
    parameter int DWELL = 16,
    parameter int BLANK = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic [PINS*(PINS-1)-1:0]      pixels,
    input  logic [$clog2(DWELL+1)-1:0]    brightness,
    output logic [PINS-1:0]               pin_oe,
    output logic [PINS-1:0]               pin_out,
    output logic [$clog2(PINS)-1:0]       row,
    output logic                          frame_start
);

    localparam int NCOL = PINS - 1;
    localparam int NPIX = PINS * NCOL;
    localparam int RW   = $clog2(PINS);
    localparam int BW   = $clog2(DWELL + 1);
    localparam int CW   = width_of((DWELL > BLANK) ? DWELL : BLANK);

    localparam logic [CW-1:0] BLANK_LD = CW'(BLANK - 1);
    localparam logic [CW-1:0] DWELL_LD = CW'(DWELL - 1);
    localparam logic [RW-1:0] LAST_ROW = RW'(PINS - 1);

    state_e          state_q, state_d;
    logic [RW-1:0]   row_q, row_d;
    logic [NPIX-1:0] fb_q, fb_d;
    logic [BW-1:0]   br_q, br_d;
    logic            fs_q, fs_d;
    logic [PINS-1:0] oe_q, oe_d;
    logic [PINS-1:0] out_q, out_d;

    logic            tmr_load;
    logic [CW-1:0]   tmr_val;
    logic [CW-1:0]   tmr_count;
    logic            tmr_done;

    int              idx_d;
    logic [NCOL-1:0] row_pix;

    scan_timer #(.W(CW)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .count_o    (tmr_count),
        .done_o     (tmr_done)
    );

    // Sequencing: idle -> (blank, drive) per row -> next frame or idle; frames latch here.
    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        fb_d     = fb_q;
        br_d     = br_q;
        fs_d     = 1'b0;
        tmr_load = 1'b0;
        tmr_val  = BLANK_LD;
        unique case (state_q)
            ST_IDLE: begin
                if (en) begin
                    fb_d     = pixels;
                    br_d     = brightness;
                    fs_d     = 1'b1;
                    row_d    = '0;
                    state_d  = ST_BLANK;
                    tmr_load = 1'b1;
                end
            end
            ST_BLANK: begin
                if (tmr_done) begin
                    state_d  = ST_DRIVE;
                    tmr_load = 1'b1;
                    tmr_val  = DWELL_LD;
                end
            end
            ST_DRIVE: begin
                if (tmr_done) begin
                    if (row_q != LAST_ROW) begin
                        row_d    = row_q + 1'b1;
                        state_d  = ST_BLANK;
                        tmr_load = 1'b1;
                    end else if (en) begin
                        fb_d     = pixels;
                        br_d     = brightness;
                        fs_d     = 1'b1;
                        row_d    = '0;
                        state_d  = ST_BLANK;
                        tmr_load = 1'b1;
                    end else begin
                        state_d  = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Pad pattern for the upcoming cycle: anode on row_d, lit cathodes while the dwell index is under brightness.
    always_comb begin
        oe_d    = '0;
        out_d   = '0;
        row_pix = '0;
        // Counter runs down, so the dwell index counts up from zero on drive entry.
        idx_d   = (state_q == ST_DRIVE) ? (DWELL - int'(tmr_count)) : 0;
        for (int r = 0; r < PINS; r++) begin
            if (int'(row_d) == r) begin
                row_pix = fb_q[r*NCOL +: NCOL];
            end
        end
        if (state_d == ST_DRIVE) begin
            for (int p = 0; p < PINS; p++) begin
                if (int'(row_d) == p) begin
                    oe_d[p]  = 1'b1;
                    out_d[p] = 1'b1;
                end
            end
            if (idx_d < int'(br_q)) begin
                for (int c = 0; c < NCOL; c++) begin
                    for (int p = 0; p < PINS; p++) begin
                        if (row_pix[c] && (col_to_pin(int'(row_d), c) == p)) begin
                            oe_d[p] = 1'b1;
                        end
                    end
                end
            end
        end
    end

    // State, frame buffer and all outputs register together so they change on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            row_q   <= '0;
            fb_q    <= '0;
            br_q    <= '0;
            fs_q    <= 1'b0;
            oe_q    <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            fb_q    <= fb_d;
            br_q    <= br_d;
            fs_q    <= fs_d;
            oe_q    <= oe_d;
            out_q   <= out_d;
        end
    end

    assign pin_oe      = oe_q;
    assign pin_out     = out_q;
    assign row         = row_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_charlie_scanner.sv
// Bench for charlie_scanner: two instances (3/4/1 directed+random, 4/1/2 random) against a frame-time model.
// Latency: model predicts the outputs visible in the cycle after each sampled edge.
// Backpressure: not applicable.
module tb_charlie_scanner;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance 0: PINS=3, DWELL=4, BLANK=1
    logic       rst0 = 1'b1, en0 = 1'b0;
    logic [5:0] pix0 = '0;
    logic [2:0] br0  = '0;
    logic [2:0] oe0, out0;
    logic [1:0] row0;
    logic       fs0;

    // Instance 1: PINS=4, DWELL=1, BLANK=2
    logic        rst1 = 1'b1, en1 = 1'b0;
    logic [11:0] pix1 = '0;
    logic [0:0]  br1  = 1'b1;
    logic [3:0]  oe1, out1;
    logic [1:0]  row1;
    logic        fs1;

    charlie_scanner #(.PINS(3), .DWELL(4), .BLANK(1)) dut0 (
        .clk(clk), .rst(rst0), .en(en0), .pixels(pix0), .brightness(br0),
        .pin_oe(oe0), .pin_out(out0), .row(row0), .frame_start(fs0)
    );

    charlie_scanner #(.PINS(4), .DWELL(1), .BLANK(2)) dut1 (
        .clk(clk), .rst(rst1), .en(en1), .pixels(pix1), .brightness(br1),
        .pin_oe(oe1), .pin_out(out1), .row(row1), .frame_start(fs1)
    );

    int n_pass = 0;
    int n_tot  = 0;
    bit started = 1'b0;
    bit done    = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    endtask

    // ---------------- frame-time reference model ----------------
    // Each instance is an active flag plus a cycle position t within the frame;
    // row and phase follow from t by division against the row period.
    int          NP [2] = '{3, 4};
    int          ND [2] = '{4, 1};
    int          NB [2] = '{1, 2};
    bit          m_act [2];
    int          m_t   [2];
    int          m_row [2];
    logic [15:0] m_pix [2];
    int          m_br  [2];
    bit          m_fs  [2];
    logic [3:0]  e_oe  [2];
    logic [3:0]  e_out [2];

    task automatic model_step(input int i, input bit r, input bit e, input logic [15:0] px, input int br);
        int rp, k, d, rr, p;
        rp = NB[i] + ND[i];
        m_fs[i] = 1'b0;
        if (r) begin
            m_act[i] = 1'b0;
            m_row[i] = 0;
        end else if (!m_act[i]) begin
            if (e) begin
                m_act[i] = 1'b1; m_t[i] = 0; m_pix[i] = px; m_br[i] = br; m_fs[i] = 1'b1;
            end
        end else begin
            m_t[i]++;
            if (m_t[i] == NP[i] * rp) begin
                if (e) begin
                    m_t[i] = 0; m_pix[i] = px; m_br[i] = br; m_fs[i] = 1'b1;
                end else begin
                    m_act[i] = 1'b0;
                end
            end
        end
        e_oe[i]  = '0;
        e_out[i] = '0;
        if (m_act[i]) begin
            rr = m_t[i] / rp;
            k  = m_t[i] % rp;
            m_row[i] = rr;
            if (k >= NB[i]) begin
                d = k - NB[i];
                e_oe[i]  |= 4'(1 << rr);
                e_out[i] |= 4'(1 << rr);
                if (d < m_br[i]) begin
                    for (int c = 0; c < NP[i] - 1; c++) begin
                        if (m_pix[i][rr*(NP[i]-1) + c]) begin
                            p = (c < rr) ? c : c + 1;
                            e_oe[i] |= 4'(1 << p);
                        end
                    end
                end
            end
        end
    endtask

    always @(posedge clk) begin
        model_step(0, rst0, en0, 16'(pix0), int'(br0));
        model_step(1, rst1, en1, 16'(pix1), int'(br1));
        started = 1'b1;
    end

    // Every-cycle comparison against the model plus pad invariants.
    always @(negedge clk) begin
        if (started && !done) begin
            chk("m0_oe",  32'(oe0),  32'(e_oe[0][2:0]));
            chk("m0_out", 32'(out0), 32'(e_out[0][2:0]));
            chk("m0_row", 32'(row0), 32'(m_row[0]));
            chk("m0_fs",  32'(fs0),  32'(m_fs[0]));
            chk("m1_oe",  32'(oe1),  32'(e_oe[1]));
            chk("m1_out", 32'(out1), 32'(e_out[1]));
            chk("m1_row", 32'(row1), 32'(m_row[1]));
            chk("m1_fs",  32'(fs1),  32'(m_fs[1]));
            chk("inv0_out_within_oe", 32'(out0 & ~oe0), 0);
            chk("inv1_out_within_oe", 32'(out1 & ~oe1), 0);
            chk("inv0_one_anode", 32'($countones(oe0 & out0) <= 1), 1);
            chk("inv1_one_anode", 32'($countones(oe1 & out1) <= 1), 1);
        end
    end

    // ---------------- hand-computed expectations for instance 0 ----------------
    localparam logic [8:0] L_ONE = {3'b100, 3'b010, 3'b011}; // pixels=000001: row0 lights pin1
    localparam logic [8:0] L_ALL = 9'h1FF;                    // every pixel lit: all pins driven

    // Walk one 15-cycle frame from its frame_start cycle; optional mid-frame action at cycle act_at
    // (act 1: load all-lit image, act 2: drop en).
    task automatic walk(input string tag, input logic [8:0] lit, input int br, input int act_at, input int act);
        logic [2:0] an, xo;
        for (int k = 0; k < 15; k++) begin
            int r, ph;
            r  = k / 5;
            ph = k % 5;
            an = 3'(1 << r);
            if (ph == 0)           xo = 3'b000;
            else if (ph - 1 < br)  xo = lit[3*r +: 3];
            else                   xo = an;
            chk({tag, "_oe"},  32'(oe0),  32'(xo));
            chk({tag, "_out"}, 32'(out0), (ph == 0) ? 32'd0 : 32'(an));
            chk({tag, "_row"}, 32'(row0), 32'(r));
            chk({tag, "_fs"},  32'(fs0),  (k == 0) ? 32'd1 : 32'd0);
            if (k == act_at) begin
                if (act == 1) pix0 = 6'b111111;
                else          en0  = 1'b0;
            end
            @(negedge clk);
        end
    endtask

    task automatic next_fs(input string tag);
        int n = 0;
        @(negedge clk);
        while (fs0 !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_fs_seen"}, 32'(fs0), 1);
    endtask

    // Instance 1: fully random stimulus for the whole run.
    initial begin
        repeat (3) @(negedge clk);
        rst1 = 1'b0;
        en1  = 1'b1;
        while (!done) begin
            if ($urandom_range(59) == 0) en1 = ~en1;
            if ($urandom_range(4) == 0)  pix1 = 12'($urandom);
            if ($urandom_range(9) == 0)  br1 = 1'($urandom);
            rst1 = ($urandom_range(399) == 0);
            @(negedge clk);
        end
    end

    // Instance 0: directed scenarios, then a random soak.
    initial begin
        repeat (3) @(negedge clk);
        chk("rst_oe",  32'(oe0),  0);
        chk("rst_out", 32'(out0), 0);
        chk("rst_row", 32'(row0), 0);
        chk("rst_fs",  32'(fs0),  0);
        rst0 = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_oe", 32'(oe0), 0);
        chk("idle_fs", 32'(fs0), 0);

        // Basic scan: one lit pixel at row 0 column 0.
        pix0 = 6'b000001; br0 = 3'd4; en0 = 1'b1;
        @(negedge clk);
        walk("basic", L_ONE, 4, -1, 0);
        chk("basic_period_fs", 32'(fs0), 1);

        // PWM at half brightness, then fully dark.
        pix0 = 6'b111111; br0 = 3'd2;
        next_fs("pwm");
        walk("pwm", L_ALL, 2, -1, 0);
        br0 = 3'd0;
        next_fs("dark");
        walk("dark", L_ALL, 0, -1, 0);

        // Tearing: image change during row 1 stays invisible until the next frame.
        pix0 = 6'b000001; br0 = 3'd4;
        next_fs("tear");
        walk("tear", L_ONE, 4, 6, 1);
        walk("tear_new", L_ALL, 4, -1, 0);

        // Disable during row 1: frame completes, then silence; re-enable restarts at row 0.
        walk("dis", L_ALL, 4, 6, 2);
        begin
            int pulses = 0, lit = 0;
            repeat (20) begin
                if (fs0) pulses++;
                if (oe0 != 3'b000) lit++;
                @(negedge clk);
            end
            chk("dis_no_fs", pulses, 0);
            chk("dis_hiz", lit, 0);
        end
        en0 = 1'b1;
        @(negedge clk);
        walk("restart", L_ALL, 4, -1, 0);

        // Reset during row 2 dwell cycle 1.
        repeat (12) @(negedge clk);
        chk("pre_rst_row", 32'(row0), 2);
        chk("pre_rst_oe",  32'(oe0),  32'(3'b111));
        rst0 = 1'b1; en0 = 1'b0;
        @(negedge clk);
        chk("midrst_oe",  32'(oe0),  0);
        chk("midrst_row", 32'(row0), 0);
        chk("midrst_fs",  32'(fs0),  0);
        rst0 = 1'b0;
        repeat (5) @(negedge clk);
        chk("postrst_idle_oe", 32'(oe0), 0);

        // Random soak checked by the model.
        en0 = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(39) == 0) en0 = ~en0;
            if ($urandom_range(7) == 0)  pix0 = 6'($urandom);
            if ($urandom_range(19) == 0) br0 = 3'($urandom);
            rst0 = ($urandom_range(299) == 0);
            @(negedge clk);
        end

        done = 1'b1;
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
